// File: rtl/dec_onehot_scan.sv
// Binary-to-one-hot decoder with an auto-scan mode for multiplexed displays.
// Define DEC_ACTIVE_LOW_EN to drive o inverted (active-low digit anodes).
module dec_onehot_scan #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 2**SEL_W,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             scan_mode,
    input  logic [SEL_W-1:0] a,
    input  logic             a_valid,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] o,
    output logic [SEL_W-1:0] idx,
    output logic             o_valid,
    output logic             tick
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] O_POL = '1;
`else
    localparam logic [OUT_W-1:0] O_POL = '0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [OUT_W-1:0] hot;
    logic [OUT_W-1:0] hot_nxt;
    logic [SEL_W-1:0] idx_nxt;
    logic [SEL_W-1:0] idx_inc;
    logic             o_valid_nxt;
    logic             tick_nxt;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_nxt;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Active-high view of the registered output, whatever the polarity build.
    assign hot = o ^ O_POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else if (scan_mode) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = DECODE;
        end
    end

    // Next values of the registered outputs, keyed on the transition taken.
    always_comb begin
        hot_nxt     = hot;
        idx_nxt     = idx;
        o_valid_nxt = o_valid;
        tick_nxt    = 1'b0;
        presc_nxt   = '0;
        idx_inc     = (idx == SEL_W'(OUT_W - 1)) ? '0 : idx + SEL_W'(1);
        case (state_nxt)
            IDLE: begin
                hot_nxt     = '0;
                o_valid_nxt = 1'b0;
            end
            DECODE: begin
                if (state == DECODE && a_valid) begin
                    hot_nxt     = onehot(a);
                    idx_nxt     = a;
                    o_valid_nxt = 1'b1;
                end
            end
            SCAN: begin
                if (state != SCAN) begin
                    hot_nxt     = onehot('0);
                    idx_nxt     = '0;
                    o_valid_nxt = 1'b1;
                end else if (presc == div) begin
                    hot_nxt  = onehot(idx_inc);
                    idx_nxt  = idx_inc;
                    tick_nxt = 1'b1;
                end else begin
                    presc_nxt = presc + DIV_W'(1);
                end
            end
            default: begin
                hot_nxt     = '0;
                o_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o       <= O_POL;
            idx     <= '0;
            o_valid <= 1'b0;
            tick    <= 1'b0;
            presc   <= '0;
        end else begin
            o       <= hot_nxt ^ O_POL;
            idx     <= idx_nxt;
            o_valid <= o_valid_nxt;
            tick    <= tick_nxt;
            presc   <= presc_nxt;
        end
    end

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Bench for dec_onehot_scan: decode loads, scan sequencing, enable drop and
// asynchronous reset, checked through an expected-value queue.
module tb_dec_onehot_scan;

    localparam int SEL_W = 4;
    localparam int OUT_W = 16;
    localparam int DIV_W = 16;
    localparam int PW    = OUT_W + SEL_W + 2;

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] O_IDLE = '1;
`else
    localparam logic [OUT_W-1:0] O_IDLE = '0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             scan_mode;
    logic [SEL_W-1:0] a;
    logic             a_valid;
    logic [DIV_W-1:0] div;
    logic [OUT_W-1:0] o;
    logic [SEL_W-1:0] idx;
    logic             o_valid;
    logic             tick;

    logic [PW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            m_idx;
    int            m_p;

    dec_onehot_scan #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scan_mode (scan_mode),
        .a         (a),
        .a_valid   (a_valid),
        .div       (div),
        .o         (o),
        .idx       (idx),
        .o_valid   (o_valid),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(input logic [OUT_W-1:0] eo, input int ei,
                                         input logic ev, input logic et);
        logic [SEL_W-1:0] i4;
        i4 = SEL_W'(ei);
        return {eo, i4, ev, et};
    endfunction

    function automatic logic [OUT_W-1:0] exp_o(input int i);
        logic [OUT_W-1:0] one;
        one = 1;
        return (one << i) ^ O_IDLE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference scan behaviour for one edge, using the div value present at it.
    task automatic scan_model(output logic t);
        if (m_p == int'(div)) begin
            m_p   = 0;
            m_idx = (m_idx + 1) % OUT_W;
            t     = 1'b1;
        end else begin
            m_p = m_p + 1;
            t   = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [PW-1:0] got, exp;
        rst_n = 1'b0; en = 1'b0; scan_mode = 1'b0; a = '0; a_valid = 1'b0; div = '0;
        #3;
        exp_q.push_back(pk(O_IDLE, 0, 1'b0, 1'b0));
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset got=%h exp=%h", got, exp); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_decode();
        logic [PW-1:0] got, exp;
        en = 1'b1; scan_mode = 1'b0;
        exp_q.push_back(pk(O_IDLE, 0, 1'b0, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL decode_entry got=%h exp=%h", got, exp); end
        a = 4'hA; a_valid = 1'b1;
        exp_q.push_back(pk(exp_o(10), 10, 1'b1, 1'b0));
        step();
        a_valid = 1'b0;
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL decode_load got=%h exp=%h", got, exp); end
        for (int k = 0; k < 10; k++) begin
            a = SEL_W'($urandom_range(0, 15));
            exp_q.push_back(pk(exp_o(10), 10, 1'b1, 1'b0));
            step();
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL decode_hold got=%h exp=%h", got, exp); end
        end
        m_idx = 10;
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] got, exp;
        int            vals[3];
        vals = '{15, 0, 3};
        for (int k = 0; k < 15; k++) begin
            if (k < 3) begin
                a = SEL_W'(vals[k]); a_valid = 1'b1;
            end else begin
                a = SEL_W'($urandom_range(0, 15)); a_valid = 1'($urandom_range(0, 1));
            end
            if (a_valid) m_idx = int'(a);
            exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, 1'b0));
            step();
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_scan_div2();
        logic [PW-1:0] got, exp;
        logic          t;
        // a_valid in the same cycle as scan_mode must be ignored
        scan_mode = 1'b1; div = 16'd2; a = 4'h7; a_valid = 1'b1;
        m_idx = 0; m_p = 0;
        exp_q.push_back(pk(exp_o(0), 0, 1'b1, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL scan_entry got=%h exp=%h", got, exp); end
        for (int k = 0; k < 52; k++) begin
            a = SEL_W'($urandom_range(0, 15)); a_valid = 1'($urandom_range(0, 1));
            scan_model(t);
            exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, t));
            step();
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL scan_div2 k=%0d got=%h exp=%h", k, got, exp); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_div_change();
        logic [PW-1:0] got, exp;
        logic          t;
        scan_mode = 1'b0;
        exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL scan_to_decode got=%h exp=%h", got, exp); end
        scan_mode = 1'b1; div = 16'd3;
        m_idx = 0; m_p = 0;
        exp_q.push_back(pk(exp_o(0), 0, 1'b1, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL rescan_entry got=%h exp=%h", got, exp); end
        for (int k = 0; k < 22; k++) begin
            if (k == 2) div = 16'd6;
            scan_model(t);
            exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, t));
            step();
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL div_change k=%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_en_drop();
        logic [PW-1:0] got, exp;
        logic          t;
        scan_mode = 1'b0;
        exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL decode_pause got=%h exp=%h", got, exp); end
        scan_mode = 1'b1; div = 16'd0;
        m_idx = 0; m_p = 0;
        exp_q.push_back(pk(exp_o(0), 0, 1'b1, 1'b0));
        step();
        for (int k = 0; k < 5; k++) begin
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL div0 k=%0d got=%h exp=%h", k, got, exp); end
            scan_model(t);
            exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, t));
            step();
        end
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL div0_idx5 got=%h exp=%h", got, exp); end
        // a_valid together with en=0 must be discarded
        en = 1'b0; a = 4'h3; a_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pk(O_IDLE, 5, 1'b0, 1'b0));
            step();
            a_valid = 1'b0;
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL en_drop k=%0d got=%h exp=%h", k, got, exp); end
        end
        en = 1'b1;
        m_idx = 0; m_p = 0;
        exp_q.push_back(pk(exp_o(0), 0, 1'b1, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reenable_scan got=%h exp=%h", got, exp); end
        for (int k = 0; k < 3; k++) begin
            scan_model(t);
            exp_q.push_back(pk(exp_o(m_idx), m_idx, 1'b1, t));
            step();
            got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL reenable_run k=%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] got, exp;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pk(O_IDLE, 0, 1'b0, 1'b0));
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
        #3;
        rst_n = 1'b1;
        exp_q.push_back(pk(exp_o(0), 0, 1'b1, 1'b0));
        step();
        got = {o, idx, o_valid, tick}; exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_restart got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_scan_div2();
        test_div_change();
        test_en_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_onehot_scan.md
DEC_ONEHOT_SCAN -- requirements
Module: dec_onehot_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 4, select width; legal range 1..6.
REQ-002 The block SHALL have parameter OUT_W, default 2**SEL_W, one-hot output width; it SHALL NOT be overridden independently of SEL_W.
REQ-003 The block SHALL have parameter DIV_W, default 16, prescaler width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: block enable.
REQ-007 The block SHALL have port scan_mode, input, 1 bit: 0 = decode mode, 1 = auto-scan mode.
REQ-008 The block SHALL have port a, input, SEL_W bits: select value for decode mode.
REQ-009 The block SHALL have port a_valid, input, 1 bit: qualifies a; single-cycle load strobe.
REQ-010 The block SHALL have port div, input, DIV_W bits: scan period minus one, in clk cycles.
REQ-011 The block SHALL have port o, output, OUT_W bits: registered one-hot output.
REQ-012 The block SHALL have port idx, output, SEL_W bits: binary index of the active bit of o.
REQ-013 The block SHALL have port o_valid, output, 1 bit: o holds a valid one-hot value.
REQ-014 The block SHALL have port tick, output, 1 bit: one-cycle pulse on every scan advance.

Function
REQ-015 The block SHALL implement three states: IDLE, DECODE, SCAN.
REQ-016 IDLE SHALL be entered from any state whenever en=0, taking effect at the next edge; IDLE SHALL force o=0, o_valid=0, tick=0, and clear the prescaler; idx SHALL hold its value.
REQ-017 From IDLE with en=1, the next state SHALL be SCAN if scan_mode=1, otherwise DECODE.
REQ-018 In DECODE, a_valid=1 at an edge SHALL set o=1<<a, idx=a, o_valid=1 at that edge (latency 1 cycle from the strobe); with a_valid=0, o, idx and o_valid SHALL hold.
REQ-019 On entering DECODE from IDLE, o_valid SHALL stay 0 until the first a_valid.
REQ-020 DECODE to SCAN SHALL occur at the edge where scan_mode=1; SCAN to DECODE SHALL occur at the edge where scan_mode=0; on entering DECODE from SCAN, o, idx and o_valid SHALL hold.
REQ-021 On entry to SCAN, at the entry edge: idx=0, o=1, o_valid=1, prescaler=0, tick=0.
REQ-022 In SCAN, the prescaler SHALL increment each cycle.
REQ-023 When the prescaler equals div, at that edge: prescaler=0, idx=idx+1 modulo OUT_W (wrapping OUT_W-1 to 0), o=1<<(new idx), and tick=1 for exactly one cycle.
REQ-024 With div=0, SCAN SHALL advance every cycle, and tick SHALL stay high continuously.
REQ-025 A change of div during SCAN SHALL take effect at the next compare; if the prescaler already exceeds the new div, it SHALL count on and wrap at 2**DIV_W before matching.
REQ-026 In SCAN, a_valid SHALL be ignored, including when asserted in the same cycle as scan_mode.
REQ-027 If en=0 and a_valid=1 coincide, the block SHALL go to IDLE and discard a.
REQ-028 o SHALL always be either all-zero with o_valid=0, or exactly one-hot with o_valid=1 (OUT_W-bit arithmetic; no glitches, since o is registered).

Reset
REQ-029 When rst_n=0, the block SHALL immediately and asynchronously set state=IDLE, o=0, idx=0, o_valid=0, tick=0, and prescaler=0.
REQ-030 Deassertion of rst_n mid-scan SHALL restart the block from IDLE; no scan position SHALL be retained.

Configuration
REQ-031 With macro DEC_ACTIVE_LOW_EN defined, o SHALL be driven inverted: the idle/reset value SHALL be all-ones and the active bit SHALL be 0, for direct drive of active-low digit anodes.
REQ-032 Under DEC_ACTIVE_LOW_EN, idx, o_valid and tick SHALL be unaffected.
REQ-033 Without DEC_ACTIVE_LOW_EN, o SHALL be active-high as described above.

Verification
REQ-034 Scenario: reset, en=1, scan_mode=0, a=4'hA with a_valid for 1 cycle -> next cycle o=16'h0400, idx=4'hA, o_valid=1; o holds for 10 further idle cycles.
REQ-035 Scenario: a=4'hF then a=4'h0 on consecutive cycles with a_valid -> o=16'h8000, then o=16'h0001; latency 1 cycle each.
REQ-036 Scenario: scan_mode=1, div=2 -> o=0001, 0001, 0001, 0002, ...; tick high every 3rd cycle; after o=8000 the next o=0001 (wrap).
REQ-037 Scenario: mid-scan at idx=5, drop en -> next cycle o=0, o_valid=0, idx=5; re-enable in scan mode -> restart at idx=0.
REQ-038 Scenario: pulse rst_n low asynchronously between edges during SCAN -> outputs reach reset values before the next edge.
REQ-039 Scenario: with DEC_ACTIVE_LOW_EN and a=4'h3 -> o=16'hFFF7; after reset, o=16'hFFFF.
